// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary-to-BCD converter and the display path.
//   state_t     : converter FSM states
//   bcd_digit_t : one packed BCD digit (nibble)
//   pow10()     : constant function giving 10^n, used for overflow bounds
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Width of the constant arithmetic used for decimal bounds.
    localparam int POW_W = 128;

    // 10^n, saturating to all ones if the result would not fit in POW_W bits.
    function automatic logic [POW_W-1:0] pow10(input int n);
        logic [POW_W-1:0] acc;
        logic [POW_W-1:0] sat;
        acc = POW_W'(1);
        sat = '1;
        for (int i = 0; i < n; i++) begin
            if (acc > sat / POW_W'(10)) begin
                return sat;
            end
            acc = acc * POW_W'(10);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more.
//   din  : nibble before correction
//   dout : corrected nibble; any carry out of bit 3 is dropped
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    bcd_digit_t digit;

    assign digit = din;

    // The 4-bit add wraps, so the carry never reaches the neighbouring nibble.
    assign dout  = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, binary count to packed BCD digits.
// One iteration per clock; latency is BIN_W cycles from the accept edge,
// independent of the input value.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_bin is valid this cycle
//   in_ready  : converter idle, will accept in_bin when in_valid is high
//   in_bin    : unsigned binary value (BIN_W bits)
//   out_valid : one-cycle pulse, out_bcd/out_ovf updated this cycle
//   out_bcd   : packed BCD, digit k in [4k+3:4k]; held until next completion
//   out_ovf   : last input exceeded 10^DIGITS-1, out_bcd saturated to all 9s
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CMP_W = (BIN_W > POW_W) ? BIN_W : POW_W;

    // Largest representable value; the comparison is done wide enough that a
    // bound above 2^BIN_W simply never flags overflow.
    localparam logic [CMP_W-1:0] MAX_VAL     = CMP_W'(pow10(DIGITS)) - CMP_W'(1);
    localparam bcd_digit_t       SAT_DIGIT   = 4'h9;
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               last_iter;

    logic [BIN_W-1:0]   shift_q;
    logic [SCR_W-1:0]   scratch_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend_q;

    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_nxt;
    logic [BIN_W-1:0]   shift_nxt;
    logic               in_over;

    // ------------------------------------------------------------------
    // Datapath combinational logic
    // ------------------------------------------------------------------
    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[4*d +: 4]),
            .dout (scratch_adj[4*d +: 4])
        );
    end

    // Shift {scratch, shift} left by one; the top scratch bit falls off,
    // which only happens for inputs that are saturated anyway.
    assign scratch_nxt = {scratch_adj[SCR_W-2:0], shift_q[BIN_W-1]};
    assign shift_nxt   = shift_q << 1;

    assign in_over     = CMP_W'(in_bin) > MAX_VAL;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: registers are updated with non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    last_iter = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pure decode of state: no combinational path from in_valid.
    assign in_ready = (state_q == IDLE);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every datapath register is reset (there is no memory array
            // here), so an aborted conversion leaves nothing stale behind.
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            out_valid  <= 1'b0;
            out_bcd    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                shift_q    <= in_bin;
                scratch_q  <= '0;
                cnt_q      <= CNT_LOAD;
                ovf_pend_q <= in_over;
            end else if (state_q == SHIFT) begin
                shift_q   <= shift_nxt;
                scratch_q <= scratch_nxt;
                cnt_q     <= cnt_q - CNT_W'(1);
                if (last_iter) begin
                    out_bcd   <= ovf_pend_q ? {DIGITS{SAT_DIGIT}} : scratch_nxt;
                    out_ovf   <= ovf_pend_q;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq.
// Instance a: BIN_W=14, DIGITS=4.  Instance b: BIN_W=7, DIGITS=2.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [13:0] a_in_bin;
    logic        a_out_valid;
    logic [15:0] a_out_bcd;
    logic        a_out_ovf;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [6:0]  b_in_bin;
    logic        b_out_valid;
    logic [7:0]  b_out_bcd;
    logic        b_out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_bin    (a_in_bin),
        .out_valid (a_out_valid),
        .out_bcd   (a_out_bcd),
        .out_ovf   (a_out_ovf)
    );

    bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_bin    (b_in_bin),
        .out_valid (b_out_valid),
        .out_bcd   (b_out_bcd),
        .out_ovf   (b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_rdy(input bit sel);
        return sel ? 32'(b_in_ready) : 32'(a_in_ready);
    endfunction

    function automatic logic [31:0] get_ov(input bit sel);
        return sel ? 32'(b_out_valid) : 32'(a_out_valid);
    endfunction

    function automatic logic [31:0] get_bcd(input bit sel);
        return sel ? 32'(b_out_bcd) : 32'(a_out_bcd);
    endfunction

    function automatic logic [31:0] get_ovf(input bit sel);
        return sel ? 32'(b_out_ovf) : 32'(a_out_ovf);
    endfunction

    task automatic drive(input bit sel, input logic valid, input int v);
        if (sel) begin
            b_in_valid = valid;
            b_in_bin   = 7'(v);
        end else begin
            a_in_valid = valid;
            a_in_bin   = 14'(v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single conversion: accept, count cycles to out_valid, check result and
    // that out_valid drops again on the following cycle.
    task automatic convert(input bit sel, input int v, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input int exp_lat, input string tag);
        int lat;
        bit got;
        drive(sel, 1'b1, v);
        check({tag, "_ready"}, get_rdy(sel), 32'h1);
        tick();
        drive(sel, 1'b0, v);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (get_ov(sel) == 32'h1) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_bcd"}, get_bcd(sel), exp_bcd);
        check({tag, "_ovf"}, get_ovf(sel), 32'(exp_ovf));
        tick();
        check({tag, "_pulse"}, get_ov(sel), 32'h0);
    endtask

    // Wait for completion on instance a while counting in_ready-low samples.
    // The sample just after the accept edge is counted by the caller.
    task automatic wait_done(output int lat, inout int low);
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (a_out_valid) got = 1'b1;
            else if (!a_in_ready) low++;
        end
    endtask

    // Two values on instance a with in_valid held high throughout; the
    // second value is presented right after the first is accepted.
    task automatic pair(input int v1, input int v2, input logic [31:0] e1,
                        input logic [31:0] e2, input string tag);
        int lat;
        int low;
        drive(1'b0, 1'b1, v1);
        check({tag, "_rdy1"}, get_rdy(1'b0), 32'h1);
        tick();
        drive(1'b0, 1'b1, v2);
        low = a_in_ready ? 0 : 1;
        wait_done(lat, low);
        check({tag, "_lat1"}, 32'(lat), 32'd14);
        check({tag, "_low1"}, 32'(low), 32'd14);
        check({tag, "_bcd1"}, get_bcd(1'b0), e1);
        check({tag, "_rdy2"}, get_rdy(1'b0), 32'h1);
        tick();
        drive(1'b0, 1'b0, v2);
        check({tag, "_acc2"}, get_rdy(1'b0), 32'h0);
        low = a_in_ready ? 0 : 1;
        wait_done(lat, low);
        check({tag, "_lat2"}, 32'(lat), 32'd14);
        check({tag, "_low2"}, 32'(low), 32'd14);
        check({tag, "_bcd2"}, get_bcd(1'b0), e2);
        check({tag, "_ovf2"}, get_ovf(1'b0), 32'h0);
        tick();
    endtask

    initial begin
        bit seen;
        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        a_in_bin   = '0;
        b_in_valid = 1'b0;
        b_in_bin   = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_a_ready", get_rdy(1'b0), 32'h1);
        check("rst_a_bcd",   get_bcd(1'b0), 32'h0);
        check("rst_a_valid", get_ov(1'b0),  32'h0);
        check("rst_a_ovf",   get_ovf(1'b0), 32'h0);
        check("rst_b_ready", get_rdy(1'b1), 32'h1);
        check("rst_b_bcd",   get_bcd(1'b1), 32'h0);

        // Single conversions, BIN_W=14, DIGITS=4
        convert(1'b0, 0,     32'h0000, 1'b0, 14, "zero");
        convert(1'b0, 1234,  32'h1234, 1'b0, 14, "v1234");
        convert(1'b0, 9999,  32'h9999, 1'b0, 14, "v9999");
        convert(1'b0, 5,     32'h0005, 1'b0, 14, "v5");
        convert(1'b0, 10000, 32'h9999, 1'b1, 14, "v10000");
        convert(1'b0, 16383, 32'h9999, 1'b1, 14, "v16383");
        convert(1'b0, 1234,  32'h1234, 1'b0, 14, "ovf_clear");

        // Back-to-back with in_valid held high
        pair(58, 907, 32'h0058, 32'h0907, "b2b");

        // Input changed while busy: first result unaffected, second accepted after
        pair(77, 4321, 32'h0077, 32'h4321, "busy");

        // Reset during iteration 7 of converting 8888
        drive(1'b0, 1'b1, 8888);
        tick();
        drive(1'b0, 1'b0, 8888);
        repeat (7) tick();
        check("mid_busy", get_rdy(1'b0), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", get_rdy(1'b0), 32'h1);
        check("mid_rst_valid", get_ov(1'b0),  32'h0);
        check("mid_rst_bcd",   get_bcd(1'b0), 32'h0);
        check("mid_rst_ovf",   get_ovf(1'b0), 32'h0);
        seen = 1'b0;
        repeat (2) begin
            tick();
            if (a_out_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            if (a_out_valid) seen = 1'b1;
        end
        check("mid_no_valid", 32'(seen), 32'h0);
        check("mid_bcd_hold", get_bcd(1'b0), 32'h0);
        convert(1'b0, 42, 32'h0042, 1'b0, 14, "v42");

        // BIN_W=7, DIGITS=2
        convert(1'b1, 99,  32'h99, 1'b0, 7, "b_v99");
        convert(1'b1, 100, 32'h99, 1'b1, 7, "b_v100");
        convert(1'b1, 37,  32'h37, 1'b0, 7, "b_v37");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

- Sequential double-dabble converter from a binary count to packed BCD digits.
- Sits directly upstream of the multiplexed seven-segment display driver: it accepts a binary value over a valid/ready handshake and delivers one BCD nibble per display digit.
- The display stage then decodes each nibble to segments.
- This removes per-digit decimal counters from the display path; any binary counter can now feed the display.

## Interface
- BIN_W, default 14: binary input width.
- DIGITS, default 4: number of BCD output digits; the output is 4*DIGITS bits.
- clk  in  1  system clock (100 MHz board clock).
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_bin is valid this cycle.
- in_ready  out  1  converter idle and able to accept a value.
- in_bin  in  BIN_W  unsigned binary value.
- out_valid  out  1  one-cycle pulse: out_bcd/out_ovf updated this cycle.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 (ones) in [3:0], digit k in [4k+3:4k].
- out_ovf  out  1  last input exceeded 10^DIGITS-1; out_bcd saturated.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
- IDLE to SHIFT on in_valid && in_ready. At that edge:
  - capture in_bin into the shift register;
  - clear the BCD scratch register;
  - load bit counter = BIN_W;
  - latch ovf_pend = (in_bin > 10^DIGITS-1), compared at full BIN_W width.
- Each SHIFT cycle does one iteration:
  - every scratch nibble >= 5 gets +3, with the nibble carry confined to that nibble;
  - then {scratch, shift} is shifted left by 1;
  - the counter is decremented.
- On the iteration where counter == 1:
  - out_bcd <= ovf_pend ? all nibbles 4'h9 : the post-shift scratch value;
  - out_ovf <= ovf_pend;
  - out_valid <= 1;
  - state <= IDLE.
- out_valid is a single-cycle pulse. out_bcd and out_ovf hold until the next completion.
- in_valid while in SHIFT is ignored. Holding the value is the source's responsibility (standard valid/ready).
- An overflowing input still takes the full BIN_W iterations, so latency is data-independent.
- Scratch width is 4*DIGITS. Bits shifted out of the top nibble are discarded; this only occurs on overflow inputs, which are saturated anyway.
- BIN_W >= 1 and DIGITS >= 1 are required. No other parameter constraint.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, so in_ready=1;
  - out_valid=0;
  - out_bcd=0;
  - out_ovf=0;
  - shift, scratch, counter and ovf_pend all 0.
- Accept at edge E0. Iterations occur on edges E1..E_BIN_W.
- out_valid=1 in the cycle following edge E_BIN_W. Latency is BIN_W cycles from the accept edge.
- in_ready is low from after E0 until after E_BIN_W.
- The next accept is possible at edge E_BIN_W+1, giving one conversion per BIN_W+1 cycles.
- Completion and a new accept are never in the same cycle: in_ready is low on the completing edge.
- Reset asserted mid-conversion:
  - abort immediately and return to reset values;
  - no out_valid;
  - the partial result is never visible.
- in_ready is a pure decode of state, with no combinational path from in_valid.

## Structure
- Shared package bcd_pkg holds:
  - the state enum {IDLE, SHIFT};
  - the BCD nibble type;
  - the constant function pow10(DIGITS) used for the overflow bound.
- The display driver reuses bcd_pkg for its digit type.
- One sub-module, bcd_add3: a combinational 4-bit "if >= 5 add 3" cell, instantiated DIGITS times via generate.
- The top level contains the FSM, the counter and the registers.

## Test plan
All cases use BIN_W=14, DIGITS=4 unless stated.
- After reset release, in_ready=1, out_bcd=16'h0000, out_valid=0. Send in_bin=0: out_valid exactly 14 cycles after accept, out_bcd=16'h0000, out_ovf=0.
- in_bin=1234 → 16'h1234. in_bin=9999 → 16'h9999, out_ovf=0. in_bin=5 → 16'h0005.
- in_bin=10000 → 16'h9999 with out_ovf=1. in_bin=16383 → 16'h9999 with out_ovf=1. Latency is still 14 cycles.
- Back-to-back 58 then 907 with in_valid held high:
  - second accept on the edge after the first out_valid;
  - results 16'h0058 then 16'h0907;
  - in_ready low for exactly 14 cycles each time.
- Change in_bin to 4321 while busy converting 77: the result is 16'h0077, and 4321 is accepted only once in_ready=1.
- Assert rst_n=0 at iteration 7 of converting 8888: out_valid never pulses, and all outputs go to reset values. Then convert 42 → 16'h0042.
- DIGITS=2, BIN_W=7: in_bin=99 → 8'h99. in_bin=100 → 8'h99 with out_ovf=1. Latency is 7 cycles.
